// File: rtl/sabiranje_arbitar_if.sv
// Request/result bundle for the shared-adder arbiter: per-lane operand handshake
// plus a single result handshake carrying sum, flags and requester index.
interface sabiranje_arbitar_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 7,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_z;
  logic                 res_carry;
  logic                 res_ovf;
  logic [ID_W-1:0]      res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_z, res_carry, res_ovf, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_z, res_carry, res_ovf, res_id
  );
endinterface

// File: rtl/sabiranje_arbitar.sv
// Round-robin arbiter sequencing up to NUM_REQ requesters through one W-bit adder:
// accept one operand pair, add in a dedicated cycle, hold the result until taken.
module sabiranje_arbitar #(
  parameter int NUM_REQ = 4,
  parameter int W       = 7,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sabiranje_arbitar_if.slave      bus,
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StAdd, StOut} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    z_q, z_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic [ID_W-1:0] rid_q, rid_d;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum;

  // Search starts one past the last grant and wraps, so the last winner is tried last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel = bus.req_a[i*W +: W];
        b_sel = bus.req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (state_q == StIdle) && found && (winner == ID_W'(i));
    end
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    z_d     = z_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    rid_d   = rid_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = winner;
          last_d  = winner;
          state_d = StAdd;
        end
      end
      StAdd: begin
        z_d     = sum[W-1:0];
        carry_d = sum[W];
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
        rid_d   = id_q;
        state_d = StOut;
      end
      StOut: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= ID_W'(NUM_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rid_q   <= rid_d;
    end
  end

  assign bus.res_valid = (state_q == StOut);
  assign bus.res_z     = z_q;
  assign bus.res_carry = carry_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.res_id    = rid_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sabiranje_arbitar.sv
// Scoreboard bench for sabiranje_arbitar: directed operand vectors push expected
// results; a negedge monitor pops and compares on every result handshake.
module tb_sabiranje_arbitar;
  localparam int NUM_REQ = 4;
  localparam int W       = 7;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [W-1:0]    z;
    logic            c;
    logic            o;
    logic [ID_W-1:0] id;
  } res_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_fail;
  int   cyc;
  res_t exp_q[$];

  sabiranje_arbitar_if #(.NUM_REQ(NUM_REQ), .W(W), .ID_W(ID_W)) bus ();

  sabiranje_arbitar #(.NUM_REQ(NUM_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_id", int'(bus.res_id), -1);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_z", int'(bus.res_z), int'(e.z));
        check("res_carry", int'(bus.res_carry), int'(e.c));
        check("res_ovf", int'(bus.res_ovf), int'(e.o));
        check("res_id", int'(bus.res_id), int'(e.id));
      end
    end
  end

  task automatic push(input int z, input int c, input int o, input int id);
    res_t e;
    e.z  = W'(z);
    e.c  = c[0];
    e.o  = o[0];
    e.id = ID_W'(id);
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input int idx, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(bus.req_ready), 1 << idx);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic issue(input int idx, input int a, input int b,
                       input int z, input int c, input int o);
    @(posedge clk); #1;
    bus.req_a[idx*W +: W] = W'(a);
    bus.req_b[idx*W +: W] = W'(b);
    bus.req_valid[idx]    = 1'b1;
    wait_ready(idx, "grant");
    push(z, c, o, idx);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    #23;
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_z", int'(bus.res_z), 0);
    check("rst_res_id", int'(bus.res_id), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add with latency and busy profile
    @(posedge clk); #1;
    bus.req_a[0 +: W] = 7'd5;
    bus.req_b[0 +: W] = 7'd3;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("basic_grant", int'(bus.req_ready), 1);
    push(8, 0, 0, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("basic_busy_t1", int'(busy), 1);
    check("basic_valid_t1", int'(bus.res_valid), 0);
    @(negedge clk);
    check("basic_busy_t2", int'(busy), 1);
    check("basic_valid_t2", int'(bus.res_valid), 1);
    @(negedge clk);
    check("basic_idle_t3", int'(busy), 0);

    // Wrap-around and overflow vectors
    issue(2, 100, 50, 22, 1, 0);
    wait_idle();
    issue(2, 60, 10, 70, 0, 1);
    wait_idle();
    issue(3, 127, 1, 0, 1, 0);
    wait_idle();
    issue(0, 64, 64, 0, 1, 1);
    wait_idle();

    // Backpressure with late-dropped req3 pulse
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    issue(1, 70, 70, 12, 1, 1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("bp_res_valid_seen", int'(bus.res_valid), 1);
    end
    @(posedge clk); #1;
    bus.req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", int'(bus.res_valid), 1);
      check("bp_z", int'(bus.res_z), 12);
      check("bp_flags", int'({bus.res_carry, bus.res_ovf}), 3);
      check("bp_id", int'(bus.res_id), 1);
      check("bp_no_grant", int'(bus.req_ready), 0);
      @(posedge clk); #1;
      bus.req_valid = (i == 4) ? 4'b0000 : 4'b0111;
      bus.res_ready = (i == 4);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_idle", int'(busy), 0);
      check("drop_no_grant", int'(bus.req_ready), 0);
    end

    // Reset during ADD with req1 granted
    @(posedge clk); #1;
    bus.req_a[W +: W] = 7'd1;
    bus.req_b[W +: W] = 7'd2;
    bus.req_valid = 4'b0010;
    wait_ready(1, "rst_mid_grant");
    @(posedge clk); #1;
    bus.req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(bus.res_valid), 0);
    check("rst_mid_z", int'(bus.res_z), 0);
    check("rst_mid_flags", int'({bus.res_carry, bus.res_ovf}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_result", int'(bus.res_valid), 0);
    end
    @(posedge clk); #1;
    bus.req_a[0 +: W] = 7'd7;
    bus.req_b[0 +: W] = 7'd8;
    bus.req_a[W +: W] = 7'd9;
    bus.req_b[W +: W] = 7'd9;
    bus.req_valid = 4'b0011;
    @(negedge clk);
    check("post_rst_first", int'(bus.req_ready), 1);
    push(15, 0, 0, 0);
    wait_ready(1, "post_rst_second");
    push(18, 0, 0, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();

    // Round-robin from a fresh reset with all lanes valid
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*W +: W] = W'(10 + i);
      bus.req_b[i*W +: W] = W'(20 + i);
    end
    bus.req_valid = 4'b1111;
    begin
      int prev;
      prev = 0;
      for (int g = 0; g < 5; g++) begin
        int lane;
        lane = g % NUM_REQ;
        wait_ready(lane, "rr_grant");
        if (g > 0) check("rr_spacing", cyc - prev, 3);
        prev = cyc;
        push(30 + 2 * lane, 0, 0, lane);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle();
    repeat (2) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sabiranje_arbitar.md
Name: sabiranje_arbitar

Overview:
- Round-robin arbiter and sequencer that shares one 7-bit adder datapath (z = a + b, mod 128) among up to four requesters in the ALU.
- Accepts one operand pair at a time over a valid/ready handshake and computes the sum in a dedicated cycle.
- Returns the sum with carry, signed-overflow flag and requester ID over a valid/ready result port.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..4.
- W, 7, operand and result width; must match the shared adder width.
- ID_W, 2, width of res_id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*W  operand a, requester i at bits [i*W +: W].
- req_b  input  NUM_REQ*W  operand b, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_z  output  W  sum mod 2^W.
- res_carry  output  1  unsigned carry out (bit W of a+b).
- res_ovf  output  1  signed overflow: a[W-1]==b[W-1] and z[W-1]!=a[W-1].
- res_id  output  ID_W  index of the requester that produced the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready=0, res_valid=0, res_z=0, res_carry=0, res_ovf=0, res_id=0, busy=0.
  - Operand registers are cleared.
- FSM states: IDLE, ADD, OUT.
- IDLE:
  - The winner is the first i with req_valid[i]=1, searching from last_grant+1 upward with wrap-around.
  - req_ready is combinational, one-hot on the winner, all zeros if no valid.
  - On transfer: latch a, b and winner ID; last_grant<=winner; go to ADD.
  - No valid: stay in IDLE.
  - A requester dropping valid before it is granted simply loses that cycle; no state change results.
- ADD (1 cycle):
  - Compute a+b at W+1 bits on the latched operands.
  - Register res_z, res_carry, res_ovf and res_id.
  - Go to OUT.
  - req_ready=0.
- OUT:
  - res_valid=1; all result outputs are held stable until res_ready=1.
  - On res_valid & res_ready: res_valid<=0 and go to IDLE.
  - req_ready=0 throughout OUT, even if requests are pending.
- Latency and throughput:
  - Operand accepted at edge T → res_valid high from T+2.
  - Minimum 3 cycles per operation: accept, add, output.
- Result stays valid:
  - res_z, res_carry, res_ovf and res_id keep their last values after handshake until the next ADD.
  - Consumers qualify these outputs with res_valid.
- Arithmetic:
  - Unsigned wrap-around mod 2^W; the carry reports the wrap.
  - Overflow is computed on the same bits, treated as two's complement.
- Simultaneous events:
  - A result handshake in OUT and pending requests in the same cycle → IDLE next cycle, grant the cycle after that.
  - A requester holding valid across its own grant gets at most one transfer per pass through IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...; no requester waits more than NUM_REQ operations.
- Reset mid-operation: the in-flight operation is dropped with no result emitted, and grant priority restarts at requester 0.
- Unused requester lanes (i >= NUM_REQ) are not present; no X propagation from unconnected inputs.

Test Plan:
- Basic add:
  - Stimulus: only req0 valid with a=5, b=3; res_ready=1.
  - Required: req_ready=0001 at T; res_valid at T+2 with z=8, carry=0, ovf=0, id=0; busy high T+1..T+2.
- Wrap-around and overflow:
  - Stimulus: req2 with a=100, b=50.
  - Required: z=22, carry=1, ovf=0.
  - Stimulus: then a=60, b=10.
  - Required: z=70, carry=0, ovf=1, id=2.
- Round-robin:
  - Stimulus: all four req_valid held high, res_ready=1.
  - Required: grant order 0,1,2,3,0; grants spaced 3 cycles apart; res_id follows the same order.
- Backpressure:
  - Stimulus: res_ready low for 5 cycles in OUT.
  - Required: res_valid stays 1; z, carry, ovf and id are stable; req_ready=0 for all lanes despite pending valids.
  - Stimulus: then raise res_ready.
  - Required: IDLE next cycle.
- Reset mid-op:
  - Stimulus: assert rst_n=0 asynchronously during ADD with req1 granted.
  - Required: outputs zero immediately; no res_valid after release.
  - Stimulus: reqs 1 and 0 both valid after release.
  - Required: req0 is granted first.
- Late drop:
  - Stimulus: req3 valid for one cycle while in OUT, then deasserted.
  - Required: no grant to req3 and no result with id=3.
